// File: rtl/switch_if.sv
// Switch core bus: tagged ingress words, per-output read control and VOQ status.
interface switch_if #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);
    localparam int W_IN      = 1 + 2*WIDTH_SEL + DATA_WIDTH;

    logic [PORT_NUB*W_IN-1:0]       port_in;
    logic [PORT_NUB*DATA_WIDTH-1:0] port_out;
    logic [PORT_NUB*WIDTH_SEL-1:0]  rd_sel;
    logic [PORT_NUB-1:0]            rd_en;
    logic [PORT_NUB*PORT_NUB-1:0]   empty;
    logic                           full;

    modport master (
        output port_in, rd_sel, rd_en,
        input  port_out, empty, full
    );

    modport slave (
        input  port_in, rd_sel, rd_en,
        output port_out, empty, full
    );
endinterface

// File: rtl/switch_module.sv
// Shared-buffer packet switch: one FIFO per (destination, source) pair, drained
// by each output through rd_sel/rd_en with a registered read port.
module switch_module #(
    parameter int PORT_NUB    = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    switch_if.slave  bus
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);
    localparam int W_IN      = 1 + 2*WIDTH_SEL + DATA_WIDTH;
    localparam int NQ        = PORT_NUB*PORT_NUB;
    localparam int AW        = $clog2(QUEUE_DEPTH);
    localparam int CW        = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] CNT_HWM  = CW'(QUEUE_DEPTH - 1);

    // Queue q = dest*PORT_NUB + source, which is also its bit in empty.
    logic [DATA_WIDTH-1:0] mem_r [NQ][QUEUE_DEPTH];
    logic [AW-1:0]         wr_ptr_r [NQ];
    logic [AW-1:0]         rd_ptr_r [NQ];
    logic [CW-1:0]         cnt_r [NQ];
    logic [DATA_WIDTH-1:0] port_out_r [PORT_NUB];

    logic [NQ-1:0]         push_s;
    logic [NQ-1:0]         pop_s;
    logic [DATA_WIDTH-1:0] in_data_s [PORT_NUB];
    logic [WIDTH_SEL-1:0]  in_rx_s [PORT_NUB];
    logic [PORT_NUB-1:0]   in_valid_s;
    logic [PORT_NUB-1:0]   tx_unused_s;
    logic                  full_s;

    // Split each ingress slice into its fields; tx_port plays no part in switching.
    always_comb begin
        for (int i = 0; i < PORT_NUB; i++) begin
            in_data_s[i]   = bus.port_in[i*W_IN +: DATA_WIDTH];
            tx_unused_s[i] = ^bus.port_in[i*W_IN + DATA_WIDTH +: WIDTH_SEL];
            in_rx_s[i]     = bus.port_in[i*W_IN + DATA_WIDTH + WIDTH_SEL +: WIDTH_SEL];
            in_valid_s[i]  = bus.port_in[i*W_IN + W_IN - 1];
        end
    end

    // Pop decode: an out-of-range rd_sel matches no queue, so it never pops.
    always_comb begin
        pop_s = {NQ{1'b0}};
        for (int o = 0; o < PORT_NUB; o++) begin
            for (int s = 0; s < PORT_NUB; s++) begin
                pop_s[o*PORT_NUB + s] = bus.rd_en[o]
                    && (int'(bus.rd_sel[o*WIDTH_SEL +: WIDTH_SEL]) == s)
                    && (cnt_r[o*PORT_NUB + s] != CNT_ZERO);
            end
        end
    end

    // Push decode: a full queue still accepts when it is popped in the same cycle.
    always_comb begin
        push_s = {NQ{1'b0}};
        for (int d = 0; d < PORT_NUB; d++) begin
            for (int i = 0; i < PORT_NUB; i++) begin
                push_s[d*PORT_NUB + i] = in_valid_s[i]
                    && (int'(in_rx_s[i]) == d)
                    && ((cnt_r[d*PORT_NUB + i] != CNT_MAX) || pop_s[d*PORT_NUB + i]);
            end
        end
    end

    // Queue storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (push_s[q]) begin
                mem_r[q][wr_ptr_r[q]] <= in_data_s[q % PORT_NUB];
            end
        end
    end

    // Queue pointers, occupancy counts and the registered read ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int q = 0; q < NQ; q++) begin
                wr_ptr_r[q] <= {AW{1'b0}};
                rd_ptr_r[q] <= {AW{1'b0}};
                cnt_r[q]    <= CNT_ZERO;
            end
            for (int o = 0; o < PORT_NUB; o++) begin
                port_out_r[o] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (push_s[q]) begin
                    wr_ptr_r[q] <= wr_ptr_r[q] + PTR_ONE;
                end
                if (pop_s[q]) begin
                    rd_ptr_r[q] <= rd_ptr_r[q] + PTR_ONE;
                end
                case ({push_s[q], pop_s[q]})
                    2'b10:   cnt_r[q] <= cnt_r[q] + CNT_ONE;
                    2'b01:   cnt_r[q] <= cnt_r[q] - CNT_ONE;
                    default: cnt_r[q] <= cnt_r[q];
                endcase
            end
            for (int o = 0; o < PORT_NUB; o++) begin
                for (int s = 0; s < PORT_NUB; s++) begin
                    if (pop_s[o*PORT_NUB + s]) begin
                        port_out_r[o] <= mem_r[o*PORT_NUB + s][rd_ptr_r[o*PORT_NUB + s]];
                    end
                end
            end
        end
    end

    // Status flags follow the counts directly so sources see them the same cycle.
    always_comb begin
        full_s    = 1'b0;
        bus.empty = {NQ{1'b0}};
        for (int q = 0; q < NQ; q++) begin
            bus.empty[q] = (cnt_r[q] == CNT_ZERO);
            full_s       = full_s | (cnt_r[q] >= CNT_HWM);
        end
        bus.full = full_s;
    end

    // Flatten the read registers onto the output bus.
    always_comb begin
        bus.port_out = {(PORT_NUB*DATA_WIDTH){1'b0}};
        for (int o = 0; o < PORT_NUB; o++) begin
            bus.port_out[o*DATA_WIDTH +: DATA_WIDTH] = port_out_r[o];
        end
    end
endmodule

// File: tb/tb_switch_module.sv
// Randomised and directed bench for switch_module against a queue-based model.
module tb_switch_module;
    localparam int P  = 4;
    localparam int DW = 8;
    localparam int QD = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    switch_if #(.PORT_NUB(P), .DATA_WIDTH(DW)) bus ();
    switch_module #(.PORT_NUB(P), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic       in_valid [P];
    logic [1:0] in_rx    [P];
    logic [1:0] in_tx    [P];
    logic [7:0] in_data  [P];
    logic [1:0] rd_sel_v [P];
    logic [3:0] rd_en_v;

    // reference state: one FIFO per (dest, source) and the last word read per output
    logic [7:0] voq_m [P*P][$];
    logic [7:0] out_m [P];

    int tests_run    = 0;
    int tests_failed = 0;

    always_comb begin
        bus.port_in = '0;
        bus.rd_sel  = '0;
        for (int i = 0; i < P; i++) begin
            bus.port_in[i*13 +: 13] = {in_valid[i], in_rx[i], in_tx[i], in_data[i]};
            bus.rd_sel[i*2 +: 2]    = rd_sel_v[i];
        end
        bus.rd_en = rd_en_v;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < P; i++) begin
            in_valid[i] = 1'b0; in_rx[i] = 2'd0; in_tx[i] = 2'd0;
            in_data[i] = 8'h00; rd_sel_v[i] = 2'd0;
        end
        rd_en_v = 4'h0;
    endtask

    // Apply one clock edge to the model: reads see pre-edge contents, then writes land.
    task automatic model_edge();
        int q;
        if (!rst_n) begin
            for (int k = 0; k < P*P; k++) voq_m[k].delete();
            for (int o = 0; o < P; o++) out_m[o] = 8'h00;
        end else begin
            for (int o = 0; o < P; o++) begin
                q = o*P + int'(rd_sel_v[o]);
                if (rd_en_v[o] && voq_m[q].size() > 0) out_m[o] = voq_m[q].pop_front();
            end
            for (int i = 0; i < P; i++) begin
                q = int'(in_rx[i])*P + i;
                if (in_valid[i] && in_rx[i] < P && voq_m[q].size() < QD) voq_m[q].push_back(in_data[i]);
            end
        end
    endtask

    task automatic step();
        logic [15:0] exp_empty;
        logic        exp_full;
        @(posedge clk);
        model_edge();
        #1;
        exp_full = 1'b0;
        for (int k = 0; k < P*P; k++) begin
            exp_empty[k] = (voq_m[k].size() == 0);
            if (voq_m[k].size() >= QD-1) exp_full = 1'b1;
        end
        check_eq("empty", bus.empty, exp_empty);
        check_eq("full", bus.full, exp_full);
        check_eq("port_out", bus.port_out, {out_m[3], out_m[2], out_m[1], out_m[0]});
    endtask

    initial begin
        for (int o = 0; o < P; o++) out_m[o] = 8'h00;
        idle();

        // reset, with reads requested throughout
        rst_n = 1'b0; rd_en_v = 4'hF;
        step(); step();
        check_eq("rst_empty", bus.empty, 32'h0000FFFF);
        check_eq("rst_full", bus.full, 32'h0);
        check_eq("rst_port_out", bus.port_out, 32'h0);
        rst_n = 1'b1; idle();

        // single word through VOQ[2][1]
        in_valid[1] = 1'b1; in_rx[1] = 2'd2; in_tx[1] = 2'd1; in_data[1] = 8'h12;
        step(); idle();
        check_eq("t2_written", bus.empty[9], 32'h0);
        rd_sel_v[2] = 2'd1; rd_en_v = 4'b0100;
        step(); idle();
        check_eq("t2_data", bus.port_out[23:16], 32'h12);
        check_eq("t2_drained", bus.empty[9], 32'h1);

        // FIFO order, then a read on an empty queue holds the output
        for (int k = 0; k < 3; k++) begin
            in_valid[0] = 1'b1; in_rx[0] = 2'd3; in_data[0] = 8'hA1 + 8'(k);
            step();
        end
        idle();
        rd_sel_v[3] = 2'd0; rd_en_v = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t3_order", bus.port_out[31:24], (k < 3) ? 32'hA1 + 32'(k) : 32'hA3);
        end
        idle();

        // all inputs to destination 0 at once, with traffic on output 2 alongside
        for (int i = 0; i < P; i++) begin
            in_valid[i] = 1'b1; in_rx[i] = 2'd0; in_data[i] = 8'h10 + 8'(i);
        end
        step(); idle();
        check_eq("t4_all_written", bus.empty[3:0], 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd_en_v = 4'b0101; rd_sel_v[0] = 2'(k); rd_sel_v[2] = 2'd3;
            in_valid[3] = 1'b1; in_rx[3] = 2'd2; in_data[3] = 8'h50 + 8'(k);
            step();
            check_eq("t4_out0", bus.port_out[7:0], 32'h10 + 32'(k));
            if (k > 0) check_eq("t4_out2", bus.port_out[23:16], 32'h50 + 32'(k - 1));
        end
        idle();

        // high-water mark, accept into last slot, drop beyond
        for (int k = 1; k <= 9; k++) begin
            in_valid[2] = 1'b1; in_rx[2] = 2'd1; in_data[2] = 8'(k);
            step();
            if (k == 7) check_eq("t5_full_at7", bus.full, 32'h1);
        end
        idle();
        rd_en_v = 4'b0010; rd_sel_v[1] = 2'd2;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq("t5_data", bus.port_out[15:8], 32'(k));
            check_eq("t5_full", bus.full, (k == 1) ? 32'h1 : 32'h0);
        end
        idle();
        check_eq("t5_empty", bus.empty[6], 32'h1);

        // reset pulse with data queued and a non-zero output
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b1; in_rx[i] = 2'(i + 1); in_data[i] = 8'hC0 + 8'(i);
        end
        step(); idle();
        rd_en_v = 4'b0010; rd_sel_v[1] = 2'd0;
        step(); idle();
        check_eq("t6_pre", bus.port_out[15:8], 32'hC0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t6_empty", bus.empty, 32'h0000FFFF);
        check_eq("t6_full", bus.full, 32'h0);
        check_eq("t6_port_out", bus.port_out, 32'h0);

        // random traffic in phases that alternate between filling and draining
        for (int n = 0; n < 3000; n++) begin
            int hot;
            int rd_pct;
            hot    = (n / 250) % P;
            rd_pct = ((n / 500) % 2 == 0) ? 20 : 80;
            rst_n  = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < P; i++) begin
                in_valid[i] = ($urandom_range(0, 99) < 60);
                in_rx[i]    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(hot);
                in_tx[i]    = 2'($urandom_range(0, 3));
                in_data[i]  = 8'($urandom);
                rd_sel_v[i] = 2'($urandom_range(0, 3));
                rd_en_v[i]  = ($urandom_range(0, 99) < rd_pct);
            end
            step();
        end
        rst_n = 1'b1; idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
